// File: rtl/memory_stage_pkg.sv
// Shared definitions for the execute and memory stages.
// Contents: datapath/opcode widths, load/store opcode encodings, the memory
// stage FSM state type, and small decode helpers used by memory_stage.
package memory_stage_pkg;

   localparam int DWIDTH       = 32;
   localparam int OPCODE_WIDTH = 6;

   localparam logic [OPCODE_WIDTH-1:0] OP_LB  = 6'h20;
   localparam logic [OPCODE_WIDTH-1:0] OP_LH  = 6'h21;
   localparam logic [OPCODE_WIDTH-1:0] OP_LW  = 6'h23;
   localparam logic [OPCODE_WIDTH-1:0] OP_LBU = 6'h24;
   localparam logic [OPCODE_WIDTH-1:0] OP_LHU = 6'h25;
   localparam logic [OPCODE_WIDTH-1:0] OP_SB  = 6'h28;
   localparam logic [OPCODE_WIDTH-1:0] OP_SH  = 6'h29;
   localparam logic [OPCODE_WIDTH-1:0] OP_SW  = 6'h2b;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } ms_state_t;

   function automatic logic is_load(input logic [OPCODE_WIDTH-1:0] op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
   endfunction

   function automatic logic is_store(input logic [OPCODE_WIDTH-1:0] op);
      return op inside {OP_SB, OP_SH, OP_SW};
   endfunction

   function automatic logic is_mem(input logic [OPCODE_WIDTH-1:0] op);
      return is_load(op) || is_store(op);
   endfunction

   // Halfword ops need an even address, word ops a multiple of four.
   function automatic logic is_misaligned(input logic [OPCODE_WIDTH-1:0] op,
                                          input logic [1:0]              lo);
      logic mis;
      mis = 1'b0;
      if (op inside {OP_LH, OP_LHU, OP_SH}) mis = lo[0];
      if (op inside {OP_LW, OP_SW})         mis = |lo;
      return mis;
   endfunction

   // Little-endian byte-lane enables; loads never write.
   function automatic logic [3:0] store_strb(input logic [OPCODE_WIDTH-1:0] op,
                                             input logic [1:0]              lo);
      logic [3:0] strb;
      strb = 4'b0000;
      case (op)
         OP_SB:   strb = 4'b0001 << lo;
         OP_SH:   strb = lo[1] ? 4'b1100 : 4'b0011;
         OP_SW:   strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
      return strb;
   endfunction

   // Replicate the store operand across every lane it could land in.
   function automatic logic [DWIDTH-1:0] store_data(input logic [OPCODE_WIDTH-1:0] op,
                                                    input logic [DWIDTH-1:0]       data);
      logic [DWIDTH-1:0] d;
      case (op)
         OP_SB:   d = {4{data[7:0]}};
         OP_SH:   d = {2{data[15:0]}};
         default: d = data;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// load_align: picks the addressed lane of a returned load word and extends it.
// Ports:
//   op    - captured load opcode (selects width and sign/zero extension)
//   lane  - address bits [1:0] of the load
//   rdata - raw word from data memory
//   data  - extended result for writeback
module load_align
   import memory_stage_pkg::*;
(
   input  logic [OPCODE_WIDTH-1:0] op,
   input  logic [1:0]              lane,
   input  logic [DWIDTH-1:0]       rdata,
   output logic [DWIDTH-1:0]       data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{lane, 3'b000} +: 8];
      half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
      case (op)
         OP_LB:   data = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
         OP_LBU:  data = {{(DWIDTH-8){1'b0}}, byte_sel};
         OP_LH:   data = {{(DWIDTH-16){half_sel[15]}}, half_sel};
         OP_LHU:  data = {{(DWIDTH-16){1'b0}}, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage. Non-memory ops pass through with one
// cycle of latency; loads/stores issue one data-memory request and stall the
// upstream stage until ack or timeout.
// Ports:
//   ms_clk, ms_rst            - clock, synchronous active-low reset
//   ms_i_*                    - instruction from execute (valid = ms_i_ce)
//   ms_o_mem_* / ms_i_mem_*   - data-memory request/response
//   ms_o_ce, wb_data, rd_addr, reg_write - result to writeback
//   ms_o_stall                - upstream holds its inputs while high
//   ms_o_misaligned, ms_o_bus_err - one-cycle fault pulses
//   ms_dbg_state              - current FSM state
// Handshake: a request is raised with ms_o_mem_req and every request field
// stays stable until the memory answers with a single-cycle ms_i_mem_ack
// (rdata valid in that same cycle); the request drops on the following edge.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int TIMEOUT = 16
)(
   input  logic                    ms_clk,
   input  logic                    ms_rst,
   input  logic                    ms_i_ce,
   input  logic [DWIDTH-1:0]       ms_i_alu_value,
   input  logic [OPCODE_WIDTH-1:0] ms_i_opcode,
   input  logic [DWIDTH-1:0]       ms_i_data_rt,
   input  logic [4:0]              ms_i_rd_addr,
   input  logic                    ms_i_reg_write,
   output logic                    ms_o_mem_req,
   output logic                    ms_o_mem_we,
   output logic [DWIDTH-1:0]       ms_o_mem_addr,
   output logic [DWIDTH-1:0]       ms_o_mem_wdata,
   output logic [3:0]              ms_o_mem_wstrb,
   input  logic                    ms_i_mem_ack,
   input  logic [DWIDTH-1:0]       ms_i_mem_rdata,
   output logic                    ms_o_ce,
   output logic [DWIDTH-1:0]       ms_o_wb_data,
   output logic [4:0]              ms_o_rd_addr,
   output logic                    ms_o_reg_write,
   output logic                    ms_o_stall,
   output logic                    ms_o_misaligned,
   output logic                    ms_o_bus_err,
   output ms_state_t               ms_dbg_state
);

   localparam int CW = $clog2(TIMEOUT + 1);

   ms_state_t               state;
   logic [CW-1:0]           wait_cnt;
   logic [OPCODE_WIDTH-1:0] op_q;
   logic [1:0]              lane_q;
   logic [4:0]              rd_q;
   logic [DWIDTH-1:0]       load_data;

   load_align u_load_align (
      .op    (op_q),
      .lane  (lane_q),
      .rdata (ms_i_mem_rdata),
      .data  (load_data)
   );

   assign ms_o_stall   = (state == ST_WAIT);
   assign ms_dbg_state = state;

   always_ff @(posedge ms_clk) begin
      if (!ms_rst) begin
         state           <= ST_IDLE;
         wait_cnt        <= '0;
         op_q            <= '0;
         lane_q          <= '0;
         rd_q            <= '0;
         ms_o_mem_req    <= 1'b0;
         ms_o_mem_we     <= 1'b0;
         ms_o_mem_addr   <= '0;
         ms_o_mem_wdata  <= '0;
         ms_o_mem_wstrb  <= '0;
         ms_o_ce         <= 1'b0;
         ms_o_wb_data    <= '0;
         ms_o_rd_addr    <= '0;
         ms_o_reg_write  <= 1'b0;
         ms_o_misaligned <= 1'b0;
         ms_o_bus_err    <= 1'b0;
      end else begin
         // Pulses and the writeback enable are only meaningful for one cycle.
         ms_o_ce         <= 1'b0;
         ms_o_misaligned <= 1'b0;
         ms_o_bus_err    <= 1'b0;
         ms_o_reg_write  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ms_i_ce) begin
                  if (!is_mem(ms_i_opcode)) begin
                     ms_o_ce        <= 1'b1;
                     ms_o_wb_data   <= ms_i_alu_value;
                     ms_o_rd_addr   <= ms_i_rd_addr;
                     ms_o_reg_write <= ms_i_reg_write;
                  end else if (is_misaligned(ms_i_opcode, ms_i_alu_value[1:0])) begin
                     ms_o_misaligned <= 1'b1;
                  end else begin
                     ms_o_mem_req   <= 1'b1;
                     ms_o_mem_we    <= is_store(ms_i_opcode);
                     ms_o_mem_addr  <= {ms_i_alu_value[DWIDTH-1:2], 2'b00};
                     ms_o_mem_wdata <= store_data(ms_i_opcode, ms_i_data_rt);
                     ms_o_mem_wstrb <= store_strb(ms_i_opcode, ms_i_alu_value[1:0]);
                     op_q           <= ms_i_opcode;
                     lane_q         <= ms_i_alu_value[1:0];
                     rd_q           <= ms_i_rd_addr;
                     wait_cnt       <= '0;
                     state          <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (ms_i_mem_ack) begin
                  ms_o_mem_req   <= 1'b0;
                  ms_o_ce        <= 1'b1;
                  ms_o_wb_data   <= load_data;
                  ms_o_rd_addr   <= rd_q;
                  ms_o_reg_write <= is_load(op_q);
                  state          <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
                  // Counter is about to reach TIMEOUT-1: abandon the access.
                  if (wait_cnt == CW'(TIMEOUT - 2)) begin
                     ms_o_mem_req <= 1'b0;
                     ms_o_bus_err <= 1'b1;
                     state        <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
